loader_seq_ctrl: RTL and testbench

Sequencer that drives the loader tree's SELECT_LEVEL/ADDRESS pair from a table of configuration words held in a synchronous config memory. On START it walks COUNT entries from BASE, fetches each word and presents it as ADDRESS. For each entry it raises SELECT_LEVEL for a fixed hold time, then drops it for a fixed gap, so the level-sensitive loader sees one clean select per entry. It sits between the host/config master and the loader top.

---
 rtl/loader_seq_pkg.sv | 31 +++
 rtl/loader_seq_timer.sv | 26 ++
 rtl/loader_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_loader_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_seq_pkg.sv
// loader_seq_pkg: shared types and sizing helpers for the loader sequencer.
package loader_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    DRIVE,
    GAP,
    FINISH
  } state_t;

  // Width of the slave-level target field carried in the top bits of each word.
  function automatic int tgt_w(input int nb_slaves);
    return $clog2(nb_slaves + 2);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Shared timer must hold the largest of hold, gap and timeout loads.
  function automatic int tmr_w(input int hold, input int gap, input int tmo);
    return $clog2(max3(hold, gap, tmo) + 1);
  endfunction

  localparam int DEF_TMR_W = tmr_w(2, 1, 15);

endpackage

// File: rtl/loader_seq_timer.sv
// loader_seq_timer: loadable down-counter; o_zero flags expiry. Shared by
// the hold, gap and read-timeout phases of the sequencer.
module loader_seq_timer
  import loader_seq_pkg::*;
#(
  parameter int W = DEF_TMR_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge CLK) begin
    if (!RESET)            r_cnt <= '0;
    else if (i_load)       r_cnt <= i_val;
    else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/loader_seq_ctrl.sv
// loader_seq_ctrl: walks COUNT config words from BASE, presents each as
// ADDRESS and frames it with one SELECT_LEVEL pulse followed by a gap.
// Optional build macro LOADER_SEQ_TARGET_CHECK_EN: words whose target field
// exceeds NB_SLAVES+2 raise ERROR and are skipped (no select pulse).
module loader_seq_ctrl
  import loader_seq_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 10,
  parameter int MEM_ADDR_SIZE  = 8,
  parameter int COUNT_SIZE     = 8,
  parameter int NB_SLAVES      = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [MEM_ADDR_SIZE-1:0] BASE,
  input  logic [COUNT_SIZE-1:0]    COUNT,
  input  logic                     ABORT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERROR,
  output logic                     MEM_RD_EN,
  output logic [MEM_ADDR_SIZE-1:0] MEM_ADDR,
  input  logic                     MEM_RD_VALID,
  input  logic [ADDRESS_SIZE-1:0]  MEM_RD_DATA,
  output logic                     SELECT_LEVEL,
  output logic [ADDRESS_SIZE-1:0]  ADDRESS
);

  localparam int TMR_W = tmr_w(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TGT_W = tgt_w(NB_SLAVES);

  state_t                   r_state;
  logic [MEM_ADDR_SIZE-1:0] r_ptr;
  logic [COUNT_SIZE-1:0]    r_rem;
  logic                     r_busy, r_done, r_err, r_rd_en, r_sel;
  logic [MEM_ADDR_SIZE-1:0] r_mem_addr;
  logic [ADDRESS_SIZE-1:0]  r_addr;

  logic             w_ld;
  logic [TMR_W-1:0] w_ld_val;
  logic             w_zero;
  logic             w_tgt_bad;

`ifdef LOADER_SEQ_TARGET_CHECK_EN
  // Extra bit so NB_SLAVES+2 is representable even when it is a power of two.
  localparam logic [TGT_W:0] TGT_MAX = (TGT_W+1)'(NB_SLAVES + 2);
  assign w_tgt_bad = ({1'b0, MEM_RD_DATA[ADDRESS_SIZE-1 -: TGT_W]} > TGT_MAX);
`else
  assign w_tgt_bad = 1'b0;
`endif

  // Timer loads: a timer loaded with N-1 expires after N cycles in the phase;
  // the read timeout loads the full count so WAIT_DATA lasts TIMEOUT+1 cycles.
  always_comb begin
    w_ld     = 1'b0;
    w_ld_val = '0;
    case (r_state)
      FETCH: begin
        w_ld     = 1'b1;
        w_ld_val = TMR_W'(TIMEOUT_CYCLES);
      end
      WAIT_DATA: if (MEM_RD_VALID) begin
        w_ld     = 1'b1;
        w_ld_val = w_tgt_bad ? TMR_W'(GAP_CYCLES - 1) : TMR_W'(HOLD_CYCLES - 1);
      end
      DRIVE: if (w_zero) begin
        w_ld     = 1'b1;
        w_ld_val = TMR_W'(GAP_CYCLES - 1);
      end
      default: ;
    endcase
  end

  loader_seq_timer #(.W(TMR_W)) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_load (w_ld),
    .i_val  (w_ld_val),
    .o_zero (w_zero)
  );

  // Sequencer FSM with registered outputs; strobes default low each cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_en    <= 1'b0;
      r_sel      <= 1'b0;
      r_mem_addr <= '0;
      r_addr     <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_sel   <= 1'b0;
      if (ABORT && r_state != IDLE) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (START && !ABORT) begin
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            if (COUNT != '0) begin
              r_ptr   <= BASE;
              r_rem   <= COUNT;
              r_state <= FETCH;
            end else begin
              r_state <= FINISH;
            end
          end
          FETCH: begin
            r_rd_en    <= 1'b1;
            r_mem_addr <= r_ptr;
            r_state    <= WAIT_DATA;
          end
          WAIT_DATA: begin
            if (MEM_RD_VALID) begin
              if (w_tgt_bad) begin
                r_err   <= 1'b1;
                r_state <= GAP;
              end else begin
                r_addr  <= MEM_RD_DATA;
                r_state <= DRIVE;
              end
            end else if (w_zero) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          DRIVE: begin
            r_sel <= 1'b1;
            if (w_zero) r_state <= GAP;
          end
          GAP: if (w_zero) begin
            r_ptr   <= r_ptr + 1'b1;
            r_rem   <= r_rem - 1'b1;
            r_state <= (r_rem == COUNT_SIZE'(1)) ? FINISH : FETCH;
          end
          FINISH: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign ERROR        = r_err;
  assign MEM_RD_EN    = r_rd_en;
  assign MEM_ADDR     = r_mem_addr;
  assign SELECT_LEVEL = r_sel;
  assign ADDRESS      = r_addr;

endmodule

// File: tb/tb_loader_seq_ctrl.sv
// tb_loader_seq_ctrl: table-driven sequence runs against a latency-configurable
// memory model, plus hand-written abort/reset/error corner cases.
module tb_loader_seq_ctrl;

  logic       CLK = 1'b0, RESET = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic [7:0] BASE = '0, COUNT = '0;
  logic       BUSY, DONE, ERROR, MEM_RD_EN, SELECT_LEVEL;
  logic [7:0] MEM_ADDR;
  logic       MEM_RD_VALID = 1'b0;
  logic [9:0] MEM_RD_DATA = '0;
  logic [9:0] ADDRESS;

  loader_seq_ctrl dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE(BASE), .COUNT(COUNT),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR(MEM_ADDR), .MEM_RD_VALID(MEM_RD_VALID),
    .MEM_RD_DATA(MEM_RD_DATA), .SELECT_LEVEL(SELECT_LEVEL), .ADDRESS(ADDRESS)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;

  // Memory model: a strobe seen at a negedge answers mem_lat negedges later
  // (lat 1 = valid sampled on the very next posedge).
  logic [9:0] mem [256];
  int         mem_lat = 1;
  bit         mem_respond = 1'b1;
  int         pend = 0;
  logic [7:0] paddr = '0;
  always @(negedge CLK) begin
    MEM_RD_VALID = 1'b0;
    if (MEM_RD_EN && mem_respond) begin
      pend  = mem_lat;
      paddr = MEM_ADDR;
    end
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        MEM_RD_VALID = 1'b1;
        MEM_RD_DATA  = mem[paddr];
      end
    end
  end

  // Monitor: DONE pulses, read addresses, select pulses (address, width).
  int         done_cnt = 0;
  logic [7:0] rd_q[$];
  logic [9:0] sel_q[$];
  int         w_q[$];
  int         sel_run = 0, unstable = 0;
  logic       sel_prev = 1'b0;
  logic [9:0] sel_hold = '0;
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (MEM_RD_EN) rd_q.push_back(MEM_ADDR);
    if (SELECT_LEVEL && !sel_prev) begin
      sel_q.push_back(ADDRESS);
      sel_hold = ADDRESS;
      sel_run  = 1;
    end else if (SELECT_LEVEL) begin
      sel_run++;
      if (ADDRESS !== sel_hold) unstable++;
    end
    if (!SELECT_LEVEL && sel_prev) w_q.push_back(sel_run);
    sel_prev = SELECT_LEVEL;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Issue START; edges = posedges after the START edge until BUSY reads low.
  task automatic run_seq(input logic [7:0] b, input logic [7:0] c, output int edges);
    @(negedge CLK);
    BASE = b; COUNT = c; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    edges = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (!BUSY) begin edges = n; break; end
      @(posedge CLK);
    end
  endtask

  function automatic bit tgt_bad(input logic [9:0] w);
`ifdef LOADER_SEQ_TARGET_CHECK_EN
    return w[9:7] > 3'd6;
`else
    return (w == 10'h000) && (w != 10'h000);
`endif
  endfunction

  typedef struct {
    logic [7:0] base;
    logic [7:0] cnt;
    int         lat;
    bit         respond;
    int         exp_edges;
    bit         exp_err;
    int         exp_done;
  } vec_t;
  vec_t tbl[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int edges, rb, sb, wb, db, ub, k;
    logic [7:0] a;
    logic [9:0] exp_sel[$];

    for (int i = 0; i < 256; i++) mem[i] = 10'(i) ^ 10'h0A5;
    mem[8'h10] = 10'h105; mem[8'h11] = 10'h2A3; mem[8'h12] = 10'h3FF;

`ifdef LOADER_SEQ_TARGET_CHECK_EN
    tbl[0] = '{8'h10, 8'd3, 1, 1'b1, 14, 1'b1, 1};
`else
    tbl[0] = '{8'h10, 8'd3, 1, 1'b1, 16, 1'b0, 1};
`endif
    tbl[1] = '{8'hFF, 8'd2, 1, 1'b1, 11, 1'b0, 1};
    tbl[2] = '{8'h20, 8'd1, 3, 1'b1,  8, 1'b0, 1};
    tbl[3] = '{8'h05, 8'd0, 1, 1'b1,  1, 1'b0, 1};
    tbl[4] = '{8'h30, 8'd2, 1, 1'b0, 17, 1'b1, 0};

    // Reset state.
    idle(3);
    chk("rst BUSY", BUSY, 0); chk("rst DONE", DONE, 0); chk("rst ERROR", ERROR, 0);
    chk("rst RD_EN", MEM_RD_EN, 0); chk("rst SELECT", SELECT_LEVEL, 0);
    chk("rst ADDRESS", ADDRESS, 0); chk("rst MEM_ADDR", MEM_ADDR, 0);
    RESET = 1'b1;
    idle(2);

    for (int r = 0; r < 5; r++) begin
      rb = rd_q.size(); sb = sel_q.size(); wb = w_q.size(); db = done_cnt; ub = unstable;
      mem_lat = tbl[r].lat; mem_respond = tbl[r].respond;
      run_seq(tbl[r].base, tbl[r].cnt, edges);
      idle(4);
      chk($sformatf("r%0d edges", r), edges, tbl[r].exp_edges);
      chk($sformatf("r%0d ERROR", r), ERROR, tbl[r].exp_err);
      chk($sformatf("r%0d done", r), done_cnt - db, tbl[r].exp_done);
      chk($sformatf("r%0d BUSY", r), BUSY, 0);
      k = tbl[r].respond ? int'(tbl[r].cnt) : (tbl[r].cnt != 0 ? 1 : 0);
      chk($sformatf("r%0d reads", r), rd_q.size() - rb, k);
      for (int i = 0; i < k && rb + i < rd_q.size(); i++) begin
        a = tbl[r].base + 8'(i);
        chk($sformatf("r%0d rdaddr%0d", r, i), rd_q[rb+i], a);
      end
      exp_sel.delete();
      if (tbl[r].respond)
        for (int i = 0; i < int'(tbl[r].cnt); i++) begin
          a = tbl[r].base + 8'(i);
          if (!tgt_bad(mem[a])) exp_sel.push_back(mem[a]);
        end
      chk($sformatf("r%0d pulses", r), sel_q.size() - sb, exp_sel.size());
      for (int i = 0; i < exp_sel.size() && sb + i < sel_q.size(); i++) begin
        chk($sformatf("r%0d addr%0d", r, i), sel_q[sb+i], exp_sel[i]);
        if (wb + i < w_q.size())
          chk($sformatf("r%0d width%0d", r, i), w_q[wb+i], 2);
      end
      chk($sformatf("r%0d addr stable", r), unstable - ub, 0);
    end

    // ABORT+START together in IDLE: start ignored, sticky ERROR kept.
    rb = rd_q.size();
    @(negedge CLK);
    BASE = 8'h00; COUNT = 8'd1; START = 1'b1; ABORT = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0; ABORT = 1'b0;
    idle(4);
    chk("idle abort BUSY", BUSY, 0);
    chk("idle abort ERROR kept", ERROR, 1);
    chk("idle abort no read", rd_q.size() - rb, 0);

    // Next accepted START clears ERROR.
    db = done_cnt; mem_lat = 2; mem_respond = 1'b1;
    run_seq(8'h40, 8'd1, edges);
    idle(3);
    chk("clear edges", edges, 7);
    chk("clear ERROR", ERROR, 0);
    chk("clear done", done_cnt - db, 1);

    // ABORT during DRIVE of entry 2 of 4, with a simultaneous START.
    mem_lat = 1; rb = rd_q.size(); db = done_cnt;
    @(negedge CLK);
    BASE = 8'h50; COUNT = 8'd4; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    begin
      int rises; logic prev;
      rises = 0; prev = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge CLK);
        if (SELECT_LEVEL && !prev) rises++;
        prev = SELECT_LEVEL;
        if (rises == 2) break;
      end
      chk("abort reached entry2", rises, 2);
    end
    ABORT = 1'b1; START = 1'b1; COUNT = 8'd7; BASE = 8'h90;
    @(posedge CLK);
    #1 ABORT = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("abort SELECT", SELECT_LEVEL, 0);
    chk("abort BUSY", BUSY, 0);
    idle(6);
    chk("abort stays idle", BUSY, 0);
    chk("abort no done", done_cnt - db, 0);
    chk("abort reads", rd_q.size() - rb, 2);
    chk("abort ERROR", ERROR, 0);

    // ABORT in FINISH suppresses DONE.
    db = done_cnt;
    @(negedge CLK);
    COUNT = 8'd0; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0; ABORT = 1'b1;
    @(posedge CLK);
    #1 ABORT = 1'b0;
    idle(3);
    chk("finish abort no done", done_cnt - db, 0);
    chk("finish abort BUSY", BUSY, 0);

    // RESET low in GAP of entry 1.
    db = done_cnt;
    @(negedge CLK);
    BASE = 8'h60; COUNT = 8'd3; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge CLK);
        if (SELECT_LEVEL) begin seen = 1'b1; break; end
      end
      chk("gap reached", seen, 1);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("gaprst BUSY", BUSY, 0); chk("gaprst SELECT", SELECT_LEVEL, 0);
    chk("gaprst ADDRESS", ADDRESS, 0); chk("gaprst MEM_ADDR", MEM_ADDR, 0);
    chk("gaprst RD_EN", MEM_RD_EN, 0); chk("gaprst DONE", DONE, 0);
    chk("gaprst ERROR", ERROR, 0);
    RESET = 1'b1;
    idle(20);
    chk("gaprst no done", done_cnt - db, 0);
    chk("gaprst idle", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
